// File: rtl/gray_counter_4bit.sv
// gray_counter_4bit: free-running Gray-code counter.
// An internal binary count advances on every clock edge. The Gray output is
// registered from the next binary value, so the port is driven straight from
// flops and exactly one output bit changes per step, including on the wrap.
// Optional build macro GRAY_CNT_CHECK_EN adds a sticky 'err' output. It flags
// any step where the output changed in a number of bits other than one.
module gray_counter_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef GRAY_CNT_CHECK_EN
    output logic             err,
`endif
    output logic [WIDTH-1:0] gray
);

    // Binary to reflected-binary Gray conversion.
    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] bin_next;

    assign bin_next = bin + WIDTH'(1);

    // Advance the binary count and register its Gray image; reset clears both at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_next;
            gray <= bin2gray(bin_next);
        end
    end

`ifdef GRAY_CNT_CHECK_EN
    // True when exactly one bit of v is set.
    function automatic logic is_one_hot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    logic [WIDTH-1:0] gray_p1;
    logic             prev_vld;

    // Compare each new output value with the one before it and latch any
    // step that is not a single-bit change until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_p1  <= '0;
            prev_vld <= 1'b0;
            err      <= 1'b0;
        end else begin
            gray_p1  <= gray;
            prev_vld <= 1'b1;
            if (prev_vld && !is_one_hot(gray ^ gray_p1)) begin
                err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gray_counter_4bit.sv
// Testbench for gray_counter_4bit: a reference model built from the required
// Gray sequence table, checked every falling edge, plus directed literal checks.
module tb_gray_counter_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] gray;
`ifdef GRAY_CNT_CHECK_EN
    logic       err;
`endif

    gray_counter_4bit #(.WIDTH(4)) dut (
        .clk  (clk),
`ifdef GRAY_CNT_CHECK_EN
        .err  (err),
`endif
        .rst  (rst),
        .gray (gray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Required output sequence from reset, as a plain lookup table.
    logic [3:0] seq [16];
    initial begin
        seq[0]  = 4'b0000; seq[1]  = 4'b0001; seq[2]  = 4'b0011; seq[3]  = 4'b0010;
        seq[4]  = 4'b0110; seq[5]  = 4'b0111; seq[6]  = 4'b0101; seq[7]  = 4'b0100;
        seq[8]  = 4'b1100; seq[9]  = 4'b1101; seq[10] = 4'b1111; seq[11] = 4'b1110;
        seq[12] = 4'b1010; seq[13] = 4'b1011; seq[14] = 4'b1001; seq[15] = 4'b1000;
    end

    // Model: number of edges since reset release, modulo 16.
    int mcnt = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) mcnt <= 0;
        else     mcnt <= (mcnt + 1) % 16;
    end

    // Compare process: output vs. table, and single-bit-change between samples.
    logic       model_on = 1'b1;
    logic [3:0] prev_g   = 4'b0000;
    logic       prev_vld = 1'b0;
    always @(negedge clk) begin
        if (model_on) begin
            check("model_seq", gray, seq[mcnt]);
            if (prev_vld && !rst) begin
                check("hamming1", 4'($countones(gray ^ prev_g)), 4'd1);
            end
            prev_g   <= gray;
            prev_vld <= !rst;
        end else begin
            prev_vld <= 1'b0;
        end
    end

    initial begin
        rst = 1'b1;
        // Reset hold across the first posedge at t=5.
        #3 check("reset_hold_pre", gray, 4'b0000);
        #5 check("reset_hold_post_edge", gray, 4'b0000);
        #2 rst = 1'b0;                                   // t=10
        // Fifteen edges (15..155) reach the last code of the cycle.
        #150 check("count_15", gray, 4'b1000);           // t=160
        #10  check("wrap_16", gray, 4'b0000);            // t=170
        #10  check("wrap_17", gray, 4'b0001);            // t=180
        // Edge at 205 is the 20th since release: 20 mod 16 = 4 -> 0110.
        #27  check("pre_async", gray, 4'b0110);          // t=207
        rst = 1'b1;
        #1   check("async_clear", gray, 4'b0000);        // t=208, no edge yet
        #4   rst = 1'b0;                                 // t=212
        #6   check("post_async", gray, 4'b0001);         // t=218, edge 215
        // Long run: 100 more edges -> edge 101 after release, 101 mod 16 = 5.
        repeat (100) @(posedge clk);
        #1   check("long_run_101", gray, 4'b0111);       // t=1216
`ifdef GRAY_CNT_CHECK_EN
        check("err_fault_free", {3'b000, err}, 4'd0);
        rst = 1'b1;
        #1   check("err_reset_gray", gray, 4'b0000);
        #2   rst = 1'b0;                                 // t=1219
        @(posedge clk);                                  // t=1225 -> 0001
        #2   model_on = 1'b0;
        force dut.bin = 4'd2;
        #1   release dut.bin;
        @(posedge clk);
        #1   check("fault_jump", gray, 4'b0010);
        check("err_latency", {3'b000, err}, 4'd0);
        @(posedge clk);
        #1   check("err_set", {3'b000, err}, 4'd1);
        repeat (3) @(posedge clk);
        #1   check("err_sticky", {3'b000, err}, 4'd1);
        #2   rst = 1'b1;
        #1   check("err_clear", {3'b000, err}, 4'd0);
        check("fault_reset_gray", gray, 4'b0000);
        #2   rst = 1'b0;
        @(negedge clk);
        model_on = 1'b1;
        repeat (20) @(posedge clk);
        #1   check("err_after_clear", {3'b000, err}, 4'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
